uart_receiver: RTL and testbench

Serial-to-parallel UART receiver that deserializes the 8N1 frames arriving on the top-level `serial_in` pin and presents each byte on a ready/valid port. The CPU's memory-mapped UART receive data and status registers consume that port. It sits directly upstream of the CPU's UART receive path, between the FPGA pin and the CPU.

---
 rtl/uart_receiver.sv | 150 +++++++++++++++
 tb/tb_uart_receiver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with a one-byte holding register
// and a ready/valid output port.
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   serial_in      asynchronous serial line, idle high
//   data_out       received byte, LSB = first data bit on the wire
//   data_out_valid data_out holds an unconsumed byte
//   data_out_ready consumer accepts the byte when valid && ready
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun_error  one-cycle pulse: good byte dropped, holding register full
module uart_receiver #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun_error
);

   localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int unsigned CW               = $clog2(SYMBOL_EDGE_TIME);
   localparam logic [CW-1:0] SAMPLE_LAST    = CW'(SAMPLE_TIME - 1);
   localparam logic [CW-1:0] SYMBOL_LAST    = CW'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_next;
   logic          sync_meta, rx, rx_prev;
   logic [1:0]    warm;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [7:0]    shreg, shreg_next;
   logic          frame_good, frame_bad;
   logic          handshake;

   // rx carries the reset value of the synchronizer for two cycles after reset.
   // warm keeps rx_prev at 0 until rx holds a real line sample, so a line that
   // is already low at reset release never looks like a 1->0 transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b1;
         rx        <= 1'b1;
         rx_prev   <= 1'b0;
         warm      <= '0;
      end else begin
         sync_meta <= serial_in;
         rx        <= sync_meta;
         rx_prev   <= rx & warm[1];
         warm      <= {warm[0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shreg   <= shreg_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CW'(1);
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      frame_good   = 1'b0;
      frame_bad    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_next = '0;
            if (rx_prev && !rx) state_next = START;
         end
         START: begin
            if (cnt == SAMPLE_LAST) begin
               cnt_next = '0;
               if (rx) begin
                  state_next = IDLE;
               end else begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end
            end
         end
         DATA: begin
            if (cnt == SYMBOL_LAST) begin
               cnt_next     = '0;
               shreg_next   = {rx, shreg[7:1]};
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == SYMBOL_LAST) begin
               cnt_next = '0;
               if (rx) begin
                  frame_good = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_bad  = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_next = '0;
            if (rx) state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign handshake = data_out_valid && data_out_ready;

   // A handshake in the stop-sample cycle frees the register in time for the
   // new byte, so load wins over clear and no overrun is flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
         framing_error  <= 1'b0;
         overrun_error  <= 1'b0;
      end else begin
         framing_error <= frame_bad;
         overrun_error <= 1'b0;
         if (frame_good && (!data_out_valid || handshake)) begin
            data_out       <= shreg;
            data_out_valid <= 1'b1;
         end else begin
            if (frame_good) overrun_error <= 1'b1;
            if (handshake)  data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames into uart_receiver and checks every output
// each cycle against a timing-level model of the receiver, plus literal
// expectations for each scenario.
module tb_uart_receiver;

   localparam int unsigned CF  = 5_000_000;
   localparam int unsigned BR  = 115_200;
   localparam int unsigned SET = CF / BR;   // 43 cycles per bit
   localparam int unsigned S   = SET / 2;   // 21

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_error;
   logic       overrun_error;

   uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
      .clk(clk),
      .rst(rst),
      .serial_in(serial_in),
      .data_out(data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .framing_error(framing_error),
      .overrun_error(overrun_error)
   );

   initial forever #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_FRAME, M_HUNT_HIGH} mode_t;
   mode_t       mode = M_IDLE;
   logic        p1 = 1'b1, p2 = 1'b1;
   bit          v1 = 0, v2 = 0;
   bit          prev_hi = 0;
   int unsigned t0 = 0;
   logic [7:0]  m_byte = '0;
   logic [7:0]  exp_data = '0;
   logic        exp_valid = 1'b0, exp_fe = 1'b0, exp_oe = 1'b0;
   bit          model_live = 0;

   // The line value used by the receiver lags the pin by two clocks and is
   // meaningless (v==0) until two clocks after reset. A frame is decoded
   // by absolute offsets from the cycle the line was first seen low.
   initial forever begin
      logic        r, hs, good;
      bit          rv;
      int unsigned off, k;
      @(posedge clk);
      cyc++;
      if (rst) begin
         p1 = 1'b1; p2 = 1'b1; v1 = 0; v2 = 0; prev_hi = 0;
         mode = M_IDLE;
         exp_data = '0; exp_valid = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0;
         model_live = 1;
      end else begin
         r  = p2; rv = v2;
         p2 = p1; v2 = v1;
         p1 = serial_in; v1 = 1;
         hs = exp_valid && data_out_ready;
         good = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0;
         case (mode)
            M_IDLE: if (prev_hi && rv && !r) begin mode = M_FRAME; t0 = cyc; end
            M_FRAME: begin
               off = cyc - t0;
               if (off == S) begin
                  if (r) mode = M_IDLE;
               end else if (off > S && (off - S) % SET == 0) begin
                  k = (off - S) / SET;
                  if (k <= 8) m_byte[k-1] = r;
                  else if (r) begin good = 1'b1; mode = M_IDLE; end
                  else begin exp_fe = 1'b1; mode = M_HUNT_HIGH; end
               end
            end
            M_HUNT_HIGH: if (r) mode = M_IDLE;
            default: mode = M_IDLE;
         endcase
         if (good) begin
            if (!exp_valid || hs) begin exp_data = m_byte; exp_valid = 1'b1; end
            else exp_oe = 1'b1;
         end else if (hs) begin
            exp_valid = 1'b0;
         end
         prev_hi = rv && r;
      end
   end

   // per-cycle comparison
   initial forever begin
      @(negedge clk);
      if (model_live) begin
         chk("cyc_valid", data_out_valid, exp_valid);
         chk("cyc_data",  data_out,       exp_data);
         chk("cyc_ferr",  framing_error,  exp_fe);
         chk("cyc_oerr",  overrun_error,  exp_oe);
      end
   end

   // event monitor
   int         rise_cnt = 0, fe_cnt = 0, oe_cnt = 0;
   logic       prev_v = 1'b0;
   logic [7:0] cap_q[$];
   initial forever begin
      @(negedge clk);
      if (model_live) begin
         if (data_out_valid === 1'b1 && prev_v !== 1'b1) begin
            rise_cnt++;
            cap_q.push_back(data_out);
         end
         if (framing_error === 1'b1) fe_cnt++;
         if (overrun_error === 1'b1) oe_cnt++;
         prev_v = data_out_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic b, input int unsigned n);
      serial_in = b;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned stop_len);
      drive(1'b0, SET);
      for (int unsigned i = 0; i < 8; i++) drive(b[i], SET);
      drive(stop, stop_len);
   endtask

   task automatic consume();
      data_out_ready = 1'b1;
      tick(1);
      data_out_ready = 1'b0;
   endtask

   int         r0, f0, o0;
   logic [7:0] sent[16];

   initial begin
      rst = 1'b1; serial_in = 1'b1; data_out_ready = 1'b0;
      tick(10);
      rst = 1'b0;
      chk("reset_data",  data_out, 8'h00);
      chk("reset_valid", data_out_valid, 1'b0);
      chk("reset_ferr",  framing_error, 1'b0);
      chk("reset_oerr",  overrun_error, 1'b0);
      drive(1'b1, 20);

      // single byte
      r0 = rise_cnt;
      send_frame(8'h5A, 1'b1, SET);
      drive(1'b1, 50);
      chk("single_data",  data_out, 8'h5A);
      chk("single_model", exp_data, 8'h5A);
      chk("single_rises", rise_cnt - r0, 1);
      chk("single_hold",  data_out_valid, 1'b1);
      consume();
      chk("single_drop",  data_out_valid, 1'b0);
      chk("single_keep",  data_out, 8'h5A);

      // false start: low for less than half a bit
      r0 = rise_cnt; f0 = fe_cnt; o0 = oe_cnt;
      drive(1'b0, S / 2);
      drive(1'b1, 50);
      chk("false_rises", rise_cnt - r0, 0);
      chk("false_ferr",  fe_cnt - f0, 0);
      chk("false_oerr",  oe_cnt - o0, 0);
      send_frame(8'hA5, 1'b1, SET);
      drive(1'b1, 20);
      chk("after_false_data", data_out, 8'hA5);
      consume();

      // framing error, line held low
      r0 = rise_cnt; f0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 1000);
      drive(1'b1, 50);
      chk("frame_ferr",  fe_cnt - f0, 1);
      chk("frame_valid", data_out_valid, 1'b0);
      chk("frame_rises", rise_cnt - r0, 0);
      send_frame(8'hC3, 1'b1, SET);
      drive(1'b1, 20);
      chk("after_frame_data", data_out, 8'hC3);
      consume();

      // overrun with ready low
      o0 = oe_cnt;
      send_frame(8'h11, 1'b1, SET);
      send_frame(8'h22, 1'b1, SET);
      drive(1'b1, 20);
      chk("ovr_data",  data_out, 8'h11);
      chk("ovr_model", exp_data, 8'h11);
      chk("ovr_oerr",  oe_cnt - o0, 1);
      chk("ovr_valid", data_out_valid, 1'b1);
      consume();

      // ready asserted exactly in the second stop-sample cycle
      o0 = oe_cnt; r0 = rise_cnt;
      send_frame(8'h11, 1'b1, SET);
      fork
         send_frame(8'h22, 1'b1, SET);
         begin
            tick(3 + S + 9 * SET - 1);
            data_out_ready = 1'b1;
            tick(1);
            data_out_ready = 1'b0;
         end
      join
      drive(1'b1, 20);
      chk("hs_load_data",  data_out, 8'h22);
      chk("hs_load_valid", data_out_valid, 1'b1);
      chk("hs_load_oerr",  oe_cnt - o0, 0);
      chk("hs_load_rises", rise_cnt - r0, 1);
      consume();

      // reset during data bit 4
      r0 = rise_cnt; f0 = fe_cnt;
      fork
         send_frame(8'hFF, 1'b1, SET);
         begin
            tick(5 * SET + SET / 2);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
         end
      join
      drive(1'b1, 50);
      chk("rstmid_valid", data_out_valid, 1'b0);
      chk("rstmid_rises", rise_cnt - r0, 0);
      chk("rstmid_ferr",  fe_cnt - f0, 0);
      send_frame(8'h81, 1'b1, SET);
      drive(1'b1, 20);
      chk("after_rst_data", data_out, 8'h81);
      consume();

      // line low at reset release
      r0 = rise_cnt; f0 = fe_cnt;
      serial_in = 1'b0;
      tick(5);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      drive(1'b0, 200);
      drive(1'b1, 50);
      chk("lowrel_rises", rise_cnt - r0, 0);
      chk("lowrel_ferr",  fe_cnt - f0, 0);
      send_frame(8'h7E, 1'b1, SET);
      drive(1'b1, 20);
      chk("after_lowrel_data", data_out, 8'h7E);
      consume();
      drive(1'b1, 10);

      // random back-to-back stream with ready always high
      f0 = fe_cnt; o0 = oe_cnt;
      cap_q.delete();
      data_out_ready = 1'b1;
      for (int unsigned i = 0; i < 16; i++) begin
         sent[i] = 8'($urandom);
         send_frame(sent[i], 1'b1, SET);
      end
      drive(1'b1, 50);
      data_out_ready = 1'b0;
      chk("stream_count", cap_q.size(), 16);
      for (int unsigned i = 0; i < 16 && i < cap_q.size(); i++)
         chk($sformatf("stream_%0d", i), cap_q[i], sent[i]);
      chk("stream_ferr", fe_cnt - f0, 0);
      chk("stream_oerr", oe_cnt - o0, 0);

      tick(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
